// File: rtl/candle_pkg.sv
//------------------------------------------------------------------------------
// candle_pkg : shared constants and state encoding for the candle sequencer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package candle_pkg;

    localparam int NUM_CANDLES = 8;
    localparam int POS_W       = 3;
    localparam int STEP_W      = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LIGHT = 2'd1;
    localparam state_t ST_BLOW  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/candle_tick_gen.sv
//------------------------------------------------------------------------------
// candle_tick_gen : TICK_DIV down-counter with synchronous restart, one-cycle tick.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module candle_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic sys_clk,
    input  logic clr_async,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = $clog2(TICK_DIV) + 1;
    localparam logic [CNT_W-1:0] c_reload = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Restart parks the counter at zero so the first tick lands on the next cycle.
    assign o_tick = i_enable && (r_cnt == '0);

    always_ff @(posedge sys_clk or posedge clr_async) begin
        if (clr_async) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= c_reload;
        end else if (i_enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/candle_sequencer.sv
//------------------------------------------------------------------------------
// candle_sequencer : turns light/blow commands into timed one-hot set/clear strobes.
// Optional abort input enabled by macro CANDLE_SEQ_ABORT_EN.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module candle_sequencer
    import candle_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic             sys_clk,
    input  logic             clr_async,
    input  logic             start_light,
    input  logic             start_blow,
`ifdef CANDLE_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [POS_W-1:0] pos_to_set,
    output logic             set_enable,
    output logic [POS_W-1:0] pos_to_clear,
    output logic             clear_enable,
    output logic             busy,
    output logic             done
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_nxt;
    logic              w_restart;
    logic              w_tick;
    logic              w_run;
    logic              w_abort;
    logic              w_set_en;
    logic [POS_W-1:0]  w_set_pos;
    logic              w_clr_en;
    logic [POS_W-1:0]  w_clr_pos;
    logic              w_busy;
    logic              w_done;

`ifdef CANDLE_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_run = (r_state == ST_LIGHT) || (r_state == ST_BLOW);

    candle_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .sys_clk   (sys_clk),
        .clr_async (clr_async),
        .i_restart (w_restart),
        .i_enable  (w_run),
        .o_tick    (w_tick)
    );

    // Output regs are loaded from these next values, so the visible state trails r_state by one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_restart   = 1'b0;
        w_set_en    = 1'b0;
        w_set_pos   = '0;
        w_clr_en    = 1'b0;
        w_clr_pos   = '0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_light) begin
                    w_state_nxt = ST_LIGHT;
                    w_step_nxt  = '0;
                    w_restart   = 1'b1;
                end else if (start_blow) begin
                    w_state_nxt = ST_BLOW;
                    w_step_nxt  = '0;
                    w_restart   = 1'b1;
                end
            end
            ST_LIGHT, ST_BLOW: begin
                w_busy = 1'b1;
                if (w_abort) begin
                    w_state_nxt = ST_DONE;
                    w_done      = 1'b1;
                end else if (w_tick) begin
                    // One extra tick after the eighth strobe spaces done like another step.
                    if (r_step == STEP_W'(NUM_CANDLES)) begin
                        w_state_nxt = ST_DONE;
                        w_done      = 1'b1;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                        if (r_state == ST_LIGHT) begin
                            w_set_en  = 1'b1;
                            w_set_pos = r_step[POS_W-1:0];
                        end else begin
                            w_clr_en  = 1'b1;
                            w_clr_pos = POS_W'(NUM_CANDLES - 1) - r_step[POS_W-1:0];
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge clr_async) begin
        if (clr_async) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            set_enable   <= 1'b0;
            pos_to_set   <= '0;
            clear_enable <= 1'b0;
            pos_to_clear <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            set_enable   <= w_set_en;
            pos_to_set   <= w_set_pos;
            clear_enable <= w_clr_en;
            pos_to_clear <= w_clr_pos;
            busy         <= w_busy;
            done         <= w_done;
        end
    end

endmodule

`default_nettype wire
